xpb_lut_accum: RTL and testbench

- Parametrised, sequential successor to the fixed 5-bit XPB constant lookup tables used in the modular-square reduction path.
- Holds a runtime-loadable table of NUM_SEG x 2^SEG_BITS precomputed WIDTH-bit XPB constants.
- Accepts a packed vector of NUM_SEG reduction digits, looks up one constant per digit and sums them into a widened result, with valid/ready handshakes on input and output.
- Replaces one hardcoded combinational case ROM per segment with a single time-multiplexed RAM plus adder.

---
 rtl/xpb_lut_accum.sv | 191 +++++++++++++++++++
 tb/tb_xpb_lut_accum.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/xpb_lut_accum.sv
// -----------------------------------------------------------------------------
// xpb_lut_accum
//
// Runtime-loadable XPB constant table with a time-multiplexed summing engine.
// The table holds NUM_SEG segments of 2^SEG_BITS constants, each WIDTH bits.
// For an accepted vector of NUM_SEG digits, one constant per digit is read and
// accumulated into a WIDTH+ACC_W bit result, so no carry is ever lost.
// Index 0 of every segment reads as zero.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   tbl_we     table write strobe (honoured only while tbl_ready is high)
//   tbl_seg    segment of the entry being written
//   tbl_idx    digit index of the entry being written (0 is never stored)
//   tbl_data   constant to store
//   tbl_ready  table writes accepted this cycle (IDLE / DONE)
//   in_valid   digit vector valid
//   in_ready   block can accept a digit vector (IDLE only)
//   in_digits  packed digits, segment i at [(i+1)*SEG_BITS-1 : i*SEG_BITS]
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts the result
//   out_sum    sum of the looked-up constants
//   busy       lookup/accumulate in progress (LOOK or ACC)
// -----------------------------------------------------------------------------
module xpb_lut_accum #(
  parameter int WIDTH    = 1024,
  parameter int SEG_BITS = 5,
  parameter int NUM_SEG  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         tbl_we,
  input  logic [((NUM_SEG > 1) ? $clog2(NUM_SEG) : 1)-1:0] tbl_seg,
  input  logic [SEG_BITS-1:0]          tbl_idx,
  input  logic [WIDTH-1:0]             tbl_data,
  output logic                         tbl_ready,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_SEG*SEG_BITS-1:0]  in_digits,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH+((NUM_SEG > 1) ? $clog2(NUM_SEG) : 1)-1:0] out_sum,
  output logic                         busy
);

  localparam int SEG_W   = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;
  localparam int ACC_W   = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;
  localparam int SUM_W   = WIDTH + ACC_W;
  localparam int ENTRIES = 2 ** SEG_BITS;

  localparam logic [SEG_W-1:0] LAST_SEG = SEG_W'(NUM_SEG - 1);
  localparam logic [SEG_W-1:0] SEG_ONE  = SEG_W'(1);
  localparam logic [SEG_W:0]   NSEG_EXT = (SEG_W + 1)'(NUM_SEG);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOOK = 2'd1,
    S_ACC  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              r_state;
  logic [SEG_W-1:0]    r_seg;        // segment being added in ACC
  logic                r_out_valid;
  logic                r_in_ready;
  logic                r_tbl_ready;
  logic                r_busy;
  logic [SUM_W-1:0]    r_out_sum;

  logic [NUM_SEG*SEG_BITS-1:0] r_digits;
  logic [SUM_W-1:0]    r_acc;
  logic [WIDTH-1:0]    r_rdata;
  logic [WIDTH-1:0]    r_mem [NUM_SEG][ENTRIES];

  logic [SEG_BITS-1:0] w_dig [NUM_SEG];
  logic [SEG_W-1:0]    w_rseg;
  logic [SUM_W-1:0]    w_addend;
  logic [SUM_W-1:0]    w_acc_next;
  logic                w_accept;
  logic                w_tbl_wr;

  // Unpack the captured digit vector into one digit per segment.
  for (genvar g = 0; g < NUM_SEG; g++) begin : g_dig
    assign w_dig[g] = r_digits[g*SEG_BITS +: SEG_BITS];
  end

  assign w_accept = (r_state == S_IDLE) && in_valid;
  assign w_tbl_wr = tbl_we && r_tbl_ready && (tbl_idx != '0) &&
                    ({1'b0, tbl_seg} < NSEG_EXT);

  // Read address runs one segment ahead of the adder: LOOK fetches seg 0,
  // each ACC cycle fetches the segment the next ACC cycle will add.
  // On the last ACC cycle the fetch is a don't-care, so the index is held
  // in range rather than stepping past NUM_SEG-1.
  always_comb begin
    w_rseg = '0;
    if (r_state == S_ACC) begin
      w_rseg = (r_seg == LAST_SEG) ? r_seg : r_seg + SEG_ONE;
    end
  end

  // Digit 0 contributes nothing, whatever the RAM holds at that index.
  always_comb begin
    w_addend = '0;
    if (w_dig[r_seg] != '0) begin
      w_addend = {{ACC_W{1'b0}}, r_rdata};
    end
  end

  assign w_acc_next = r_acc + w_addend;

  // Table RAM: one write port, one registered read port. Not reset, so
  // contents survive rst_n.
  always_ff @(posedge clk) begin
    if (w_tbl_wr) begin
      r_mem[tbl_seg][tbl_idx] <= tbl_data;
    end
    r_rdata <= r_mem[w_rseg][w_dig[w_rseg]];
  end

  // Operand capture and running sum; the accumulator is cleared on accept,
  // so it needs no reset of its own.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_digits <= in_digits;
      r_acc    <= '0;
    end else if (r_state == S_ACC) begin
      r_acc    <= w_acc_next;
    end
  end

  // Control FSM with registered handshake/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_seg       <= '0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_in_ready  <= 1'b1;
      r_tbl_ready <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_state     <= S_LOOK;
            r_seg       <= '0;
            r_in_ready  <= 1'b0;
            r_tbl_ready <= 1'b0;
            r_busy      <= 1'b1;
          end
        end
        S_LOOK: begin
          r_state <= S_ACC;
        end
        S_ACC: begin
          if (r_seg == LAST_SEG) begin
            r_state     <= S_DONE;
            r_seg       <= '0;
            r_out_sum   <= w_acc_next;
            r_out_valid <= 1'b1;
            r_tbl_ready <= 1'b1;
            r_busy      <= 1'b0;
          end else begin
            r_seg <= r_seg + SEG_ONE;
          end
        end
        S_DONE: begin
          // in_ready rises only after the handshake edge, never in the
          // same cycle as out_ready.
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign tbl_ready = r_tbl_ready;
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign busy      = r_busy;

endmodule

// File: tb/tb_xpb_lut_accum.sv
// -----------------------------------------------------------------------------
// tb_xpb_lut_accum
//
// Directed bench for xpb_lut_accum at WIDTH=16, SEG_BITS=2, NUM_SEG=3.
// A transaction-level model tracks the table contents and the expected
// result/handshake state; a compare process checks the DUT against it on every
// falling edge, and the directed sequence pins hand-computed sums and latency.
// -----------------------------------------------------------------------------
module tb_xpb_lut_accum;

  localparam int WIDTH    = 16;
  localparam int SEG_BITS = 2;
  localparam int NUM_SEG  = 3;
  localparam int SEG_W    = 2;
  localparam int SUM_W    = 18;
  localparam int DIG_W    = NUM_SEG * SEG_BITS;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             tbl_we = 1'b0;
  logic [SEG_W-1:0] tbl_seg = '0;
  logic [SEG_BITS-1:0] tbl_idx = '0;
  logic [WIDTH-1:0] tbl_data = '0;
  logic             tbl_ready;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [DIG_W-1:0] in_digits = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [SUM_W-1:0] out_sum;
  logic             busy;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  xpb_lut_accum #(
    .WIDTH   (WIDTH),
    .SEG_BITS(SEG_BITS),
    .NUM_SEG (NUM_SEG)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tbl_we   (tbl_we),
    .tbl_seg  (tbl_seg),
    .tbl_idx  (tbl_idx),
    .tbl_data (tbl_data),
    .tbl_ready(tbl_ready),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_digits(in_digits),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [WIDTH-1:0] m_tbl [NUM_SEG][4];
  int               m_cnt   = -1;   // edges since accept, -1 when not computing
  bit               m_valid = 1'b0;
  logic [SUM_W-1:0] m_pend  = '0;
  logic [SUM_W-1:0] m_sum   = '0;

  initial begin
    for (int s = 0; s < NUM_SEG; s++)
      for (int i = 0; i < 4; i++) m_tbl[s][i] = '0;
  end

  function automatic logic [SUM_W-1:0] model_sum(input logic [DIG_W-1:0] d);
    int unsigned acc;
    int unsigned dig;
    acc = 0;
    for (int s = 0; s < NUM_SEG; s++) begin
      dig = (int'(d) >> (SEG_BITS * s)) & 3;
      if (dig != 0) acc += int'(m_tbl[s][dig]);
    end
    return SUM_W'(acc);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt   = -1;
      m_valid = 1'b0;
      m_sum   = '0;
    end else begin
      // Table accepts writes whenever no lookup is in progress.
      if (tbl_we && m_cnt < 0 && tbl_idx != 0 && tbl_seg < NUM_SEG)
        m_tbl[tbl_seg][tbl_idx] = tbl_data;
      if (m_cnt < 0 && !m_valid) begin
        if (in_valid) begin
          m_cnt  = 0;
          m_pend = model_sum(in_digits);
        end
      end else if (m_cnt >= 0) begin
        m_cnt++;
        if (m_cnt == NUM_SEG + 1) begin
          m_valid = 1'b1;
          m_sum   = m_pend;
          m_cnt   = -1;
        end
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("in_ready",  32'(in_ready),  32'(m_cnt < 0 && !m_valid));
      chk("busy",      32'(busy),      32'(m_cnt >= 0));
      chk("tbl_ready", 32'(tbl_ready), 32'(m_cnt < 0));
      if (m_valid) chk("out_sum", 32'(out_sum), 32'(m_sum));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tbl_write(input int seg, input int idx, input logic [WIDTH-1:0] data);
    tbl_we   = 1'b1;
    tbl_seg  = SEG_W'(seg);
    tbl_idx  = SEG_BITS'(idx);
    tbl_data = data;
    @(negedge clk);
    tbl_we   = 1'b0;
  endtask

  // Presents a digit vector for one edge; returns at the falling edge after accept.
  task automatic start_op(input logic [DIG_W-1:0] d);
    chk("in_ready_before_op", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_digits = d;
    @(negedge clk);
    in_valid  = 1'b0;
  endtask

  // k0 = falling edges already seen since accept. The result rises on edge
  // accept+NUM_SEG+1, first visible at falling edge number NUM_SEG+2.
  task automatic wait_result(input string name, input int k0, input logic [SUM_W-1:0] exp);
    int k;
    k = k0;
    while (!out_valid && k < 30) begin
      @(negedge clk);
      k++;
    end
    if (!out_valid) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: out_valid not seen after %0d cycles", name, k);
    end else begin
      chk({name, "_sum"}, 32'(out_sum), 32'(exp));
      chk({name, "_latency"}, 32'(k), 32'(NUM_SEG + 2));
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("in_ready_after_consume", 32'(in_ready), 32'd1);
    chk("out_valid_after_consume", 32'(out_valid), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sum",   32'(out_sum),   32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_tbl_ready", 32'(tbl_ready), 32'd1);
    chk("rst_busy",      32'(busy),      32'd0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    // seg s, idx k holds k * 16^s; idx 0 writes must be dropped.
    for (int s = 0; s < NUM_SEG; s++) begin
      for (int k = 1; k < 4; k++) tbl_write(s, k, WIDTH'(k << (4 * s)));
      tbl_write(s, 0, 16'hBEEF);
    end

    // digits seg2..seg0 = {3,2,1}: 0x300 + 0x020 + 0x001
    start_op({2'd3, 2'd2, 2'd1});
    wait_result("basic", 1, 18'h00321);
    consume();

    start_op({2'd0, 2'd0, 2'd0});
    wait_result("zero_idx", 1, 18'h0);
    consume();

    start_op({2'd0, 2'd1, 2'd0});
    wait_result("mid_only", 1, 18'h00010);
    consume();

    start_op({2'd2, 2'd3, 2'd0});
    wait_result("mixed", 1, 18'h00230);
    consume();

    // Backpressure: result held, new in_valid ignored.
    start_op({2'd3, 2'd2, 2'd1});
    wait_result("bp", 1, 18'h00321);
    in_valid  = 1'b1;
    in_digits = {2'd1, 2'd1, 2'd1};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_sum", 32'(out_sum), 32'h321);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_valid",    32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    consume();
    repeat (2) @(negedge clk);
    chk("bp_no_second_op", 32'(busy), 32'd0);

    // Table write while busy must not land.
    start_op({2'd3, 2'd2, 2'd1});
    tbl_we   = 1'b1;
    tbl_seg  = 2'd1;
    tbl_idx  = 2'd2;
    tbl_data = 16'h7777;
    repeat (3) @(negedge clk);
    tbl_we   = 1'b0;
    wait_result("busy_write", 4, 18'h00321);
    consume();
    start_op({2'd3, 2'd2, 2'd1});
    wait_result("busy_write_again", 1, 18'h00321);
    consume();

    // Reset during the ACC cycle for seg 1.
    start_op({2'd3, 2'd2, 2'd1});
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_sum",   32'(out_sum),   32'd0);
    chk("midrst_in_ready",  32'(in_ready),  32'd1);
    chk("midrst_busy",      32'(busy),      32'd0);
    chk("midrst_tbl_ready", 32'(tbl_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("midrst_no_pulse", 32'(out_valid), 32'd0);
    start_op({2'd3, 2'd2, 2'd1});
    wait_result("after_rst", 1, 18'h00321);
    consume();

    // Widening: three max entries sum to 0x2FFFD.
    for (int s = 0; s < NUM_SEG; s++)
      for (int k = 1; k < 4; k++) tbl_write(s, k, 16'hFFFF);
    start_op({2'd3, 2'd3, 2'd3});
    wait_result("overflow", 1, 18'h2FFFD);
    consume();

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
